// File: rtl/vga_pkg.sv
// vga_pkg: scan timing, framebuffer geometry, RGB field helpers
// and fetch FSM types shared by the framebuffer arbiter slice.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_TOTAL  = 800;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;

   localparam int FB_W     = 160;
   localparam int FB_H     = 120;
   localparam int SCALE    = 4;
   localparam int DATA_W   = 12;
   localparam int ADDR_W   = 15;
   localparam int COL_W    = $clog2(FB_W);
   localparam int FB_WORDS = FB_W * FB_H;

   typedef logic [DATA_W-1:0] rgb_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN
   } fetch_state_t;

   typedef enum logic {
      GNT_CPU,
      GNT_READ
   } grant_t;

   function automatic logic [3:0] rgb_r(input rgb_t c);
      return c[11:8];
   endfunction

   function automatic logic [3:0] rgb_g(input rgb_t c);
      return c[7:4];
   endfunction

   function automatic logic [3:0] rgb_b(input rgb_t c);
      return c[3:0];
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: CPU write handshake plus single-port
// framebuffer RAM bus, as seen by the arbiter (master).
interface vga_fb_arbiter_if;
   import vga_pkg::*;

   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   rgb_t              cpu_wdata;
   logic              cpu_ack;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   rgb_t              ram_wdata;
   rgb_t              ram_rdata;

   modport master (
      input  cpu_req,
      input  cpu_addr,
      input  cpu_wdata,
      output cpu_ack,
      output ram_addr,
      output ram_we,
      output ram_wdata,
      input  ram_rdata
   );

   modport slave (
      output cpu_req,
      output cpu_addr,
      output cpu_wdata,
      input  cpu_ack,
      input  ram_addr,
      input  ram_we,
      input  ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/vga_line_buf.sv
// vga_line_buf: two FB_W-word banks, one synchronous write port
// and one combinational read port.
module vga_line_buf
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic             wr_bank,
   input  logic [COL_W-1:0] wr_col,
   input  rgb_t             wr_data,
   input  logic             rd_bank,
   input  logic [COL_W-1:0] rd_col,
   output rgb_t             rd_data
);

   rgb_t mem [2][FB_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_bank][wr_col] <= wr_data;
      end
   end

   assign rd_data = mem[rd_bank][rd_col];

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the framebuffer RAM between CPU writes and
// row prefetch into a ping-pong line buffer, emitting 4x-scaled pixels.
module vga_fb_arbiter
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       x,
   input  logic [9:0]       y,
   input  logic             en,
   vga_fb_arbiter_if.master bus,
   output logic [3:0]       red,
   output logic [3:0]       green,
   output logic [3:0]       blue,
   output logic             underrun
);

   localparam int SC_SH = $clog2(SCALE);

   localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] X_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] Y_TRIG_END = 10'(V_ACTIVE - SCALE);
   localparam logic [9:0] Y_ROW0     = 10'(V_ACTIVE);
   localparam logic [9:0] Y_SWAP_END = 10'(V_ACTIVE - 1);
   localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);

   localparam logic [SC_SH-1:0]  PH_LAST  = SC_SH'(SCALE - 1);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(FB_W - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(FB_WORDS);

   fetch_state_t      state;
   fetch_state_t      state_nx;
   grant_t            last_grant;
   logic              front_sel;
   logic [ADDR_W-1:0] row_base;
   logic [COL_W-1:0]  col;

   logic              p1_vld;
   logic              p2_vld;
   logic [COL_W-1:0]  p1_col;
   logic [COL_W-1:0]  p2_col;

   logic              trig_row;
   logic              trig_zero;
   logic              trigger;
   logic              swap;
   logic              read_req;
   logic              busy;
   logic              cpu_active;
   logic              gnt_read;
   logic              gnt_cpu;
   logic              cpu_ok;
   logic [COL_W-1:0]  rd_col;
   rgb_t              pix;

   assign trig_row  = (x == '0) && (y[SC_SH-1:0] == '0)
                      && (y < Y_TRIG_END);
   assign trig_zero = (x == '0) && (y == Y_ROW0);
   assign trigger   = trig_row | trig_zero;

   assign swap = (x == X_LAST)
                 && (((y[SC_SH-1:0] == PH_LAST) && (y < Y_SWAP_END))
                     || (y == Y_LAST));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (trigger) state_nx = ST_FETCH;
         end
         ST_FETCH: begin
            if (gnt_read && (col == COL_LAST)) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!p1_vld && !p2_vld) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      read_req = 1'b0;
      busy     = 1'b1;
      unique case (state)
         ST_IDLE:  busy     = 1'b0;
         ST_FETCH: read_req = 1'b1;
         default:  read_req = 1'b0;
      endcase
   end

   // cpu_req is still high in its ack cycle; masking it avoids a second write
   assign cpu_active = bus.cpu_req && !bus.cpu_ack;
   assign gnt_read   = read_req
                       && (!cpu_active || (last_grant == GNT_CPU));
   assign gnt_cpu    = cpu_active
                       && (!read_req || (last_grant == GNT_READ));
   assign cpu_ok     = bus.cpu_addr < ADDR_END;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant    <= GNT_CPU;
         col           <= '0;
         p1_vld        <= 1'b0;
         p2_vld        <= 1'b0;
         p1_col        <= '0;
         p2_col        <= '0;
         bus.ram_addr  <= '0;
         bus.ram_we    <= 1'b0;
         bus.ram_wdata <= '0;
         bus.cpu_ack   <= 1'b0;
      end else begin
         bus.ram_we  <= 1'b0;
         bus.cpu_ack <= 1'b0;
         p1_vld      <= gnt_read;
         p1_col      <= col;
         p2_vld      <= p1_vld;
         p2_col      <= p1_col;
         if (!busy) col <= '0;
         if (gnt_read) begin
            bus.ram_addr <= row_base + ADDR_W'(col);
            col          <= col + 1'b1;
            last_grant   <= GNT_READ;
         end else if (gnt_cpu) begin
            bus.cpu_ack <= 1'b1;
            last_grant  <= GNT_CPU;
            if (cpu_ok) begin
               bus.ram_we    <= 1'b1;
               bus.ram_addr  <= bus.cpu_addr;
               bus.ram_wdata <= bus.cpu_wdata;
            end
         end
      end
   end

   // a rejected trigger leaves row_base alone so the running fetch keeps its base
   always_ff @(posedge clk) begin
      if (reset) begin
         row_base  <= '0;
         front_sel <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (trig_row && !busy) begin
            row_base <= row_base + ROW_STEP;
         end else if (trig_zero && !busy) begin
            row_base <= '0;
         end
         if (swap) front_sel <= ~front_sel;
         if ((swap || trigger) && busy) underrun <= 1'b1;
      end
   end

   assign rd_col = (x < X_ACT) ? COL_W'(x >> SC_SH) : '0;

   vga_line_buf u_line_buf (
      .clk     (clk),
      .we      (p2_vld),
      .wr_bank (~front_sel),
      .wr_col  (p2_col),
      .wr_data (bus.ram_rdata),
      .rd_bank (front_sel),
      .rd_col  (rd_col),
      .rd_data (pix)
   );

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else begin
         red   <= rgb_r(pix);
         green <= rgb_g(pix);
         blue  <= rgb_b(pix);
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench with a registered RAM model and a
// compressed scan driver for the framebuffer arbiter.
module tb_vga_fb_arbiter;
   import vga_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] x;
   logic [9:0] y;
   logic       en;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic       underrun;

   int tests = 0;
   int fails = 0;

   vga_fb_arbiter_if bus ();

   vga_fb_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .x        (x),
      .y        (y),
      .en       (en),
      .bus      (bus),
      .red      (red),
      .green    (green),
      .blue     (blue),
      .underrun (underrun)
   );

   always #20 clk = ~clk;

   rgb_t mem [FB_WORDS];
   bit   do_preload = 1'b0;

   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < FB_WORDS; i++) mem[i] <= 12'(i);
      end else begin
         if (int'(bus.ram_addr) < FB_WORDS) begin
            bus.ram_rdata <= mem[bus.ram_addr];
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         end
      end
   end

   bit          mon_on = 1'b0;
   int          reads = 0;
   int          fetches = 0;
   int          first_addr = -1;
   int          first_y = -1;
   int          zero_y = -1;
   logic [14:0] prev_addr = '0;

   always @(negedge clk) begin
      if (mon_on && (bus.ram_addr != prev_addr)) begin
         reads++;
         if (int'(bus.ram_addr) % FB_W == 0) begin
            if (fetches == 0) begin
               first_addr = int'(bus.ram_addr);
               first_y    = int'(y);
            end
            if (bus.ram_addr == '0) zero_y = int'(y);
            fetches++;
         end
      end
      prev_addr = bus.ram_addr;
   end

   initial begin
      #(40 * 100000);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1);
   end

   task automatic drive_xy(input int xx, input int yy);
      x  = 10'(xx);
      y  = 10'(yy);
      en = (xx < H_ACTIVE) && (yy < V_ACTIVE);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_line(input int yy, input int nx,
                           input int px, input rgb_t pe);
      for (int xx = 0; xx < nx; xx++) begin
         drive_xy(xx, yy);
         @(negedge clk);
         if (xx == px) begin
            tests++;
            if ({red, green, blue} !== pe) begin
               fails++;
               $display("FAIL pixel(%0d,%0d): got %h want %h",
                        xx, yy, {red, green, blue}, pe);
            end
         end
      end
      drive_xy(H_TOTAL - 1, yy);
      @(negedge clk);
   endtask

   task automatic run_frame(input bit probe);
      for (int yy = 0; yy < V_TOTAL; yy++) begin
         int   nx;
         int   px;
         rgb_t pe;
         nx = 1;
         px = -1;
         pe = '0;
         if (((yy % SCALE == 0) && (yy < V_ACTIVE - SCALE))
             || (yy == V_ACTIVE)) nx = 166;
         if (probe && (yy == 8)) begin
            px = 12;
            pe = 12'd323;
         end
         if (probe && (yy == 479)) begin
            nx = 640;
            px = 639;
            pe = 12'hABC;
         end
         if (probe && (yy == 500)) begin
            nx = 14;
            px = 12;
            pe = '0;
         end
         run_line(yy, nx, px, pe);
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      do_preload    = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      drive_xy(5, 500);
      repeat (3) @(negedge clk);
      do_preload = 1'b0;
      tests++;
      if (bus.ram_addr !== '0 || bus.ram_we !== 1'b0
          || bus.ram_wdata !== '0) begin
         fails++;
         $display("FAIL reset_ram: addr=%0d we=%b wdata=%h want 0/0/0",
                  bus.ram_addr, bus.ram_we, bus.ram_wdata);
      end
      tests++;
      if (bus.cpu_ack !== 1'b0 || underrun !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: ack=%b underrun=%b want 0/0",
                  bus.cpu_ack, underrun);
      end
      tests++;
      if ({red, green, blue} !== 12'h000) begin
         fails++;
         $display("FAIL reset_rgb: got %h want 000", {red, green, blue});
      end
      tests++;
      if (dut.state !== ST_IDLE || dut.front_sel !== 1'b0) begin
         fails++;
         $display("FAIL reset_fsm: state=%0d front=%b want 0/0",
                  dut.state, dut.front_sel);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame();
      mon_on = 1'b1;
      run_frame(1'b0);
      mon_on = 1'b0;
      tests++;
      if (fetches != 120) begin
         fails++;
         $display("FAIL frame_fetches: got %0d want 120", fetches);
      end
      tests++;
      if (reads != 19200) begin
         fails++;
         $display("FAIL frame_reads: got %0d want 19200", reads);
      end
      tests++;
      if (first_addr != 160 || first_y != 0) begin
         fails++;
         $display("FAIL first_fetch: addr=%0d y=%0d want 160/0",
                  first_addr, first_y);
      end
      tests++;
      if (zero_y != 480) begin
         fails++;
         $display("FAIL row0_fetch: y=%0d want 480", zero_y);
      end
      tests++;
      if (underrun !== 1'b0) begin
         fails++;
         $display("FAIL frame_underrun: got %b want 0", underrun);
      end
   endtask

   task automatic test_cpu_write();
      int lat;
      drive_xy(5, 500);
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = 15'd19199;
      bus.cpu_wdata = 12'hABC;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin
            lat = i;
            break;
         end
      end
      tests++;
      if (lat != 0) begin
         fails++;
         $display("FAIL write_ack_latency: got %0d want 0", lat);
      end
      tests++;
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== 15'd19199
          || bus.ram_wdata !== 12'hABC) begin
         fails++;
         $display("FAIL write_bus: we=%b addr=%0d data=%h want 1/19199/abc",
                  bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      bus.cpu_req = 1'b0;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = 15'd19200;
      bus.cpu_wdata = 12'h123;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin
            lat = i;
            break;
         end
      end
      tests++;
      if (lat != 0 || bus.ram_we !== 1'b0) begin
         fails++;
         $display("FAIL write_drop: lat=%0d we=%b want 0/0",
                  lat, bus.ram_we);
      end
      bus.cpu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_display();
      run_frame(1'b1);
   endtask

   task automatic test_contention();
      int  done_k;
      int  bad_alt;
      int  close;
      logic prev_ack;
      drive_xy(5, 500);
      pulse_reset();
      bus.cpu_addr  = 15'd5000;
      bus.cpu_wdata = 12'h5A5;
      bus.cpu_req   = 1'b1;
      drive_xy(0, 0);
      @(negedge clk);
      done_k   = -1;
      bad_alt  = 0;
      close    = 0;
      prev_ack = bus.cpu_ack;
      for (int k = 1; k <= 400; k++) begin
         drive_xy(k, 0);
         @(negedge clk);
         if (k <= 320) begin
            if (k % 2 == 1) begin
               if (bus.cpu_ack || bus.ram_we
                   || bus.ram_addr != 15'(160 + (k - 1) / 2)) bad_alt++;
            end else begin
               if (!bus.cpu_ack || !bus.ram_we) bad_alt++;
            end
         end
         if (bus.cpu_ack && prev_ack) close++;
         prev_ack = bus.cpu_ack;
         if (done_k < 0 && dut.state == ST_IDLE) done_k = k;
      end
      bus.cpu_req = 1'b0;
      tests++;
      if (bad_alt != 0) begin
         fails++;
         $display("FAIL grant_alternate: %0d bad cycles want 0", bad_alt);
      end
      tests++;
      if (close != 0) begin
         fails++;
         $display("FAIL ack_spacing: %0d back-to-back acks want 0", close);
      end
      tests++;
      if (done_k != 322) begin
         fails++;
         $display("FAIL fetch_time: got %0d want 322", done_k);
      end
   endtask

   task automatic test_underrun();
      drive_xy(5, 500);
      pulse_reset();
      drive_xy(0, 0);
      @(negedge clk);
      drive_xy(H_TOTAL - 1, 3);
      @(negedge clk);
      tests++;
      if (underrun !== 1'b1 || dut.front_sel !== 1'b1) begin
         fails++;
         $display("FAIL underrun_swap: underrun=%b front=%b want 1/1",
                  underrun, dut.front_sel);
      end
      drive_xy(5, 500);
      repeat (200) @(negedge clk);
      tests++;
      if (underrun !== 1'b1) begin
         fails++;
         $display("FAIL underrun_sticky: got %b want 1", underrun);
      end
      pulse_reset();
      tests++;
      if (underrun !== 1'b0) begin
         fails++;
         $display("FAIL underrun_clear: got %b want 0", underrun);
      end
      drive_xy(0, 0);
      @(negedge clk);
      drive_xy(0, 4);
      @(negedge clk);
      tests++;
      if (underrun !== 1'b1) begin
         fails++;
         $display("FAIL underrun_trigger: got %b want 1", underrun);
      end
   endtask

   task automatic test_reset_mid_fetch();
      int moved;
      drive_xy(5, 500);
      pulse_reset();
      drive_xy(0, 0);
      @(negedge clk);
      bus.cpu_addr  = 15'd777;
      bus.cpu_wdata = 12'h0F0;
      bus.cpu_req   = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         drive_xy(k, 0);
         @(negedge clk);
      end
      reset = 1'b1;
      bus.cpu_req = 1'b0;
      drive_xy(20, 4);
      @(negedge clk);
      tests++;
      if (dut.state !== ST_IDLE || bus.ram_we !== 1'b0) begin
         fails++;
         $display("FAIL midreset_fsm: state=%0d we=%b want 0/0",
                  dut.state, bus.ram_we);
      end
      tests++;
      if (bus.ram_addr !== '0 || bus.cpu_ack !== 1'b0
          || {red, green, blue} !== 12'h000 || underrun !== 1'b0) begin
         fails++;
         $display("FAIL midreset_out: addr=%0d ack=%b rgb=%h ur=%b want 0",
                  bus.ram_addr, bus.cpu_ack, {red, green, blue}, underrun);
      end
      reset = 1'b0;
      moved = 0;
      for (int k = 0; k < 20; k++) begin
         drive_xy(21 + k, 4);
         @(negedge clk);
         if (bus.ram_addr !== '0 || bus.ram_we !== 1'b0) moved++;
      end
      tests++;
      if (moved != 0) begin
         fails++;
         $display("FAIL midreset_no_read: %0d active cycles want 0", moved);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_cpu_write();
      test_display();
      test_contention();
      test_underrun();
      test_reset_mid_fetch();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
